// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a byte FIFO.
// Host bytes are pushed on wr_en/wr_data. Each entry is framed as
// start / 5-8 data bits (LSB first) / optional parity / 1-2 stop bits.
// A frame only starts while cts_n is low.
// Ports:
//   clk, rst        - rising-edge clock, async active-high reset
//   baud_div        - clk cycles per bit (0 behaves as 1)
//   data_bit_num    - 0..3 -> 5..8 data bits
//   stop_bit_num    - 0 -> 1 stop bit, 1 -> 2 stop bits
//   parity_en       - append a parity bit
//   parity_type     - 0 even, 1 odd
//   wr_en, wr_data  - FIFO write port
//   cts_n           - peer clear-to-send (active low)
//   tx              - serial output, idle high
//   tx_busy         - frame in progress
//   tx_done         - one-cycle pulse per finished frame
//   full            - FIFO full
//   fifo_count      - FIFO occupancy
//   overflow        - one-cycle pulse when a write is dropped
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bit_num,
    input  logic             stop_bit_num,
    input  logic             parity_en,
    input  logic             parity_type,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             cts_n,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             full,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // ---------------- FIFO ----------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;
    logic [7:0]       head;

    // full is derived from the registered count, so a write in the same
    // cycle as a pop from a full FIFO is still dropped.
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_count = count;
    assign push       = wr_en && !full;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            overflow <= wr_en && full;
        end
    end

    // ---------------- Transmitter ----------------
    state_t           state, state_nxt;
    logic [DIV_W-1:0] baud_cnt, div_q, div_eff;
    logic [7:0]       sh;
    logic [2:0]       bit_idx, last_q;
    logic             par_en_q, par_q, stop2_q, stop_left;
    logic             tx_q, done_q, frame_end, tick;
    logic [7:0]       mask;
    logic             par_calc;

    assign div_eff  = (baud_div == '0) ? DIV_W'(1) : baud_div;
    assign tick     = (baud_cnt == '0);
    // Only the configured data bits contribute to parity.
    assign mask     = 8'hFF >> (2'd3 - data_bit_num);
    assign par_calc = (^(head & mask)) ^ parity_type;

    assign tx      = tx_q;
    assign tx_busy = (state != IDLE);
    assign tx_done = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            IDLE:   if (count != '0 && !cts_n) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end
            START:  if (tick) state_nxt = DATA;
            DATA:   if (tick && bit_idx == last_q)
                        state_nxt = par_en_q ? PARITY : STOP;
            PARITY: if (tick) state_nxt = STOP;
            STOP:   if (tick && !stop_left) begin
                        state_nxt = IDLE;
                        frame_end = 1'b1;
                    end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt  <= '0;
            div_q     <= DIV_W'(1);
            sh        <= '0;
            bit_idx   <= '0;
            last_q    <= '0;
            par_en_q  <= 1'b0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            stop_left <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= frame_end;
            if (pop) begin
                // Frame configuration is frozen here for the whole frame.
                sh       <= head;
                div_q    <= div_eff;
                baud_cnt <= div_eff - DIV_W'(1);
                last_q   <= 3'd4 + {1'b0, data_bit_num};
                par_en_q <= parity_en;
                par_q    <= par_calc;
                stop2_q  <= stop_bit_num;
                bit_idx  <= '0;
                tx_q     <= 1'b0;
            end else if (state != IDLE) begin
                if (!tick) begin
                    baud_cnt <= baud_cnt - DIV_W'(1);
                end else begin
                    baud_cnt <= div_q - DIV_W'(1);
                    case (state)
                        START: begin
                            tx_q <= sh[0];
                            sh   <= sh >> 1;
                        end
                        DATA: begin
                            if (bit_idx != last_q) begin
                                tx_q    <= sh[0];
                                sh      <= sh >> 1;
                                bit_idx <= bit_idx + 3'd1;
                            end else if (par_en_q) begin
                                tx_q <= par_q;
                            end else begin
                                tx_q      <= 1'b1;
                                stop_left <= stop2_q;
                            end
                        end
                        PARITY: begin
                            tx_q      <= 1'b1;
                            stop_left <= stop2_q;
                        end
                        STOP:    stop_left <= 1'b0;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a built-in TX FIFO, a programmable baud divisor and CTS hardware flow control. Host logic pushes bytes through a simple write port. The block serialises each byte as start / 5-8 data bits (LSB first) / optional parity / 1-2 stop bits on tx. It replaces the single-shot start_tx/tx_data transmit path in the UART subsystem and sits between the host write bus and the serial pin.

Parameters:
FIFO_DEPTH, 16, number of byte entries in the TX FIFO (power of two, >= 2)
DIV_W, 16, width of the baud divisor input
CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
baud_div  input  DIV_W  clk cycles per bit period; 0 treated as 1
data_bit_num  input  2  0=5, 1=6, 2=7, 3=8 data bits
stop_bit_num  input  1  0=1 stop bit, 1=2 stop bits
parity_en  input  1  1=append parity bit
parity_type  input  1  0=even, 1=odd
wr_en  input  1  push wr_data into FIFO
wr_data  input  8  byte to transmit; bits above the data width are ignored
cts_n  input  1  active-low clear-to-send from peer
tx  output  1  serial line, idle high
tx_busy  output  1  high while the FSM is not in IDLE
tx_done  output  1  one-cycle pulse per completed frame
full  output  1  FIFO holds FIFO_DEPTH entries
fifo_count  output  CNT_W  current FIFO occupancy
overflow  output  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset (async assert, sync release): tx=1, tx_busy=0, tx_done=0, overflow=0, full=0, fifo_count=0. FIFO pointers cleared and contents discarded. FSM forced to IDLE. Reset mid-frame aborts the frame: tx goes high immediately and no tx_done is issued.
- FIFO writes:
  - wr_en with full=0 stores wr_data and increments fifo_count at that edge.
  - wr_en with full=1 drops the data and pulses overflow for one cycle. This applies even if a pop occurs in the same cycle, because full is the registered value.
  - A simultaneous write and pop leaves fifo_count unchanged.
  - Entries are transmitted strictly in write order.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If fifo_count!=0 and cts_n==0, pop the head entry and latch the byte, baud_div, data_bit_num, stop_bit_num, parity_en and parity_type. Then go to START with tx=0 registered at the same edge.
  - Latency: a write into an empty FIFO with cts_n low makes tx fall one clk after the write edge.
- Bit timing: every bit period lasts exactly max(baud_div,1) clk cycles, counted by a down-counter reloaded at each bit boundary.
- START: tx=0 for one period, then DATA.
- DATA:
  - Sends n = 5+data_bit_num bits, LSB first, one per period.
  - After bit n-1, go to PARITY if parity_en else STOP.
- PARITY:
  - tx = XOR of the n transmitted bits, inverted when parity_type=1.
  - Lasts one period, then STOP.
- STOP: tx=1 for 1 or 2 periods, then IDLE.
- Frame completion:
  - tx_done pulses for one clk in the first IDLE cycle after the final stop period.
  - A pending entry is popped in that same cycle, so back-to-back frames are separated by exactly one extra clk of tx=1.
- Config stability: configuration inputs are sampled only at the pop. Changes mid-frame affect only later frames.
- Flow control:
  - cts_n is checked only in IDLE.
  - Deassertion mid-frame lets the current frame finish.
  - While cts_n is high, the FIFO holds its data and continues to accept writes.
- Frame length: (1 + n + parity_en + 1 + stop_bit_num) * max(baud_div,1) cycles of tx_busy=1.

Test Plan:
- Reset, baud_div=4, 8N1, cts_n=0, write 0xA5 -> tx falls 1 clk after write; sequence 0,1,0,1,0,0,1,0,1,1 at 4 clk/bit; tx_done pulses 40 clk after tx falls; fifo_count returns to 0.
- 7 data bits, even parity, 2 stop, write 0x35 -> data 1,0,1,0,1,1,0, parity 0, stop 1,1 (11 bits). Repeat with odd parity -> parity bit 1.
- 5 data bits, odd parity, write 0xFF -> five 1s sent, parity bit 0, bits 7:5 not transmitted; frame is 8 bit periods.
- FIFO_DEPTH=16, cts_n=1, write 17 bytes 0x00..0x10 -> full after 16th; overflow pulse on 17th; fifo_count=16; tx stays 1. Release cts_n -> 16 frames 0x00..0x0F in order, each gap exactly 1 clk; 16 tx_done pulses.
- Raise cts_n during DATA of frame 1 with 2 bytes queued -> frame 1 completes with tx_done; tx stays 1 and fifo_count=1 until cts_n falls, then frame 2 starts next clk.
- Assert rst during DATA with 3 entries queued -> tx=1 and tx_busy=0 asynchronously, fifo_count=0, no tx_done; after release with no writes, tx stays idle.
